vs_sdi_tx: RTL and testbench

Serial byte transmitter that streams MP3 bitstream bytes to the VS10xx decoder's SDI port. It sits directly downstream of the buffer that produces MP3 data bytes. It accepts bytes over a valid/ready handshake and shifts each one out MSB-first on SCLK/MOSI. Transfers are gated by the decoder's DREQ line and grouped into XDCS-framed bursts.

---
 rtl/vs_sdi_tx_pkg.sv | 17 +
 rtl/vs_sdi_tx_if.sv | 10 +
 rtl/vs_sdi_tx_sclk_tick_gen.sv | 24 ++
 rtl/vs_sdi_tx.sv | 131 +++++++++++++
 tb/tb_vs_sdi_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vs_sdi_tx_pkg.sv
// Shared types and constants for the VS10xx SDI byte transmitter.
package vs_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_DREQ = 2'd0,
    READY     = 2'd1,
    SHIFT     = 2'd2,
    HOLD      = 2'd3
  } state_t;

  // Decoder guarantees this much FIFO space per DREQ grant
  localparam int VS_BURST_BYTES = 32;

  // SPI mode 0: SCLK idles low, data sampled on the rising edge
  localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/vs_sdi_tx_if.sv
// Byte-stream handshake from the MP3 buffer into the SDI transmitter.
interface vs_sdi_tx_if;
  logic [7:0] Din;
  logic       Din_Valid;
  logic       Din_Ready;
  logic       Flush;

  modport master (output Din, output Din_Valid, output Flush, input Din_Ready);
  modport slave  (input Din, input Din_Valid, input Flush, output Din_Ready);
endinterface

// File: rtl/vs_sdi_tx_sclk_tick_gen.sv
// Half-period counter: one-cycle tick every CLK_DIV cycles while enabled.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)               r_cnt <= '0;
    else if (!i_en || o_tick) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/vs_sdi_tx.sv
// SDI transmitter: DREQ-gated, XDCS-framed bursts of MSB-first bytes on SCLK/MOSI.
module vs_sdi_tx
  import vs_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int BURST_LEN = VS_BURST_BYTES
) (
  input  logic        Clk,
  input  logic        Reset,
  vs_sdi_tx_if.slave  din_if,
  input  logic        Dreq,
  output logic        SCLK,
  output logic        MOSI,
  output logic        XDCS,
  output logic        Busy
);

  localparam int             BCW       = $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST_LEN);
  localparam logic [BCW-1:0] BURST_PRE = BCW'(BURST_LEN - 1);

  state_t         r_state, w_state_nxt;
  logic           r_dreq_m, r_dreq_s;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit;
  logic           r_sclk, r_mosi;
  logic [BCW-1:0] r_count;
  logic           w_tick, w_tick_en, w_hs, w_byte_done, w_din_ready;

  assign w_tick_en   = (r_state == SHIFT) || (r_state == HOLD);
  assign w_hs        = (r_state == READY) && din_if.Din_Valid;
  assign w_byte_done = (r_state == SHIFT) && w_tick && r_sclk && (r_bit == 3'd7);

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  // Dreq comes from the decoder's clock domain
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dreq_m <= 1'b0;
      r_dreq_s <= 1'b0;
    end else begin
      r_dreq_m <= Dreq;
      r_dreq_s <= r_dreq_m;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= WAIT_DREQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_DREQ: if (r_dreq_s) w_state_nxt = READY;
      // A handshake takes priority over a coincident flush
      READY: begin
        if (w_hs)              w_state_nxt = SHIFT;
        else if (din_if.Flush) w_state_nxt = (r_count == '0) ? WAIT_DREQ : HOLD;
      end
      SHIFT: if (w_byte_done) w_state_nxt = (r_count == BURST_PRE) ? HOLD : READY;
      HOLD:  if (w_tick)      w_state_nxt = WAIT_DREQ;
      default:                w_state_nxt = WAIT_DREQ;
    endcase
  end

  always_comb begin
    w_din_ready = 1'b0;
    Busy        = 1'b1;
    XDCS        = 1'b0;
    case (r_state)
      WAIT_DREQ: begin
        Busy = 1'b0;
        XDCS = 1'b1;
      end
      // Chip select stays asserted between bytes of a burst already under way
      READY: begin
        w_din_ready = 1'b1;
        XDCS        = (r_count == '0);
      end
      default: ;
    endcase
  end

  assign din_if.Din_Ready = w_din_ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sclk  <= SCLK_IDLE;
      r_mosi  <= 1'b0;
      r_bit   <= 3'd0;
      r_count <= '0;
    end else begin
      if (r_state == WAIT_DREQ)                       r_count <= '0;
      else if (w_byte_done && (r_count != BURST_MAX)) r_count <= r_count + 1'b1;

      if (w_hs) begin
        r_mosi <= din_if.Din[7];
        r_bit  <= 3'd0;
        r_sclk <= SCLK_IDLE;
      end else if ((r_state == SHIFT) && w_tick) begin
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else begin
          r_sclk <= 1'b0;
          if (r_bit != 3'd7) begin
            r_bit  <= r_bit + 3'd1;
            r_mosi <= r_shift[6];
          end
        end
      end
    end
  end

  // Payload only; control state above decides when it is meaningful
  always_ff @(posedge Clk) begin
    if (w_hs)
      r_shift <= din_if.Din;
    else if ((r_state == SHIFT) && w_tick && r_sclk && (r_bit != 3'd7))
      r_shift <= {r_shift[6:0], 1'b0};
  end

  assign SCLK = r_sclk;
  assign MOSI = r_mosi;

endmodule

// File: tb/tb_vs_sdi_tx.sv
// Directed bench for vs_sdi_tx with CLK_DIV=2, BURST_LEN=32.
module tb_vs_sdi_tx;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Dreq = 1'b0;
  logic SCLK, MOSI, XDCS, Busy;

  vs_sdi_tx_if bus ();

  vs_sdi_tx #(.CLK_DIV(2), .BURST_LEN(32)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .din_if (bus.slave),
    .Dreq   (Dreq),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .XDCS   (XDCS),
    .Busy   (Busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Decoder-side receiver: sample MOSI on each SCLK rise
  logic [7:0] mon_sr = 8'h00;
  int         mon_bits = 0;
  int         rise_cnt = 0;
  int         xdcs_bad = 0;
  logic [7:0] rxq[$];

  always @(posedge SCLK or posedge Reset) begin
    if (Reset) begin
      mon_bits <= 0;
    end else begin
      rise_cnt <= rise_cnt + 1;
      if (XDCS !== 1'b0) xdcs_bad <= xdcs_bad + 1;
      mon_sr <= {mon_sr[6:0], MOSI};
      if (mon_bits == 7) begin
        rxq.push_back({mon_sr[6:0], MOSI});
        mon_bits <= 0;
      end else begin
        mon_bits <= mon_bits + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int max_cyc);
    int n = 0;
    while (bus.Din_Ready !== 1'b1 && n < max_cyc) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("din_ready_wait", {31'd0, bus.Din_Ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.Din       = b;
    bus.Din_Valid = 1'b1;
    wait_ready(80);
    @(posedge Clk); #1;
    bus.Din_Valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = (rxq.size() > 0) ? {24'd0, rxq.pop_front()} : 32'h1FF;
    chk(tag, got, {24'd0, exp});
  endtask

  task automatic flush_burst();
    bus.Flush = 1'b1;
    @(posedge Clk); #1;
    bus.Flush = 1'b0;
    wait_ready(40);
  endtask

  initial begin
    int cyc;
    int r0;
    bus.Din       = 8'h00;
    bus.Din_Valid = 1'b0;
    bus.Flush     = 1'b0;

    // Reset state
    repeat (3) @(posedge Clk); #1;
    chk("rst_sclk", {31'd0, SCLK}, 32'd0);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_xdcs", {31'd0, XDCS}, 32'd1);
    chk("rst_ready", {31'd0, bus.Din_Ready}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;

    // Flow control: Dreq low blocks everything
    bus.Din = 8'h3C;
    bus.Din_Valid = 1'b1;
    repeat (10) @(posedge Clk); #1;
    chk("fc_ready_low", {31'd0, bus.Din_Ready}, 32'd0);
    chk("fc_no_sclk", rise_cnt, 32'd0);
    chk("fc_xdcs", {31'd0, XDCS}, 32'd1);
    Dreq = 1'b1;
    @(posedge Clk); #1; chk("fc_lat_e1", {31'd0, bus.Din_Ready}, 32'd0);
    @(posedge Clk); #1; chk("fc_lat_e2", {31'd0, bus.Din_Ready}, 32'd0);
    @(posedge Clk); #1; chk("fc_lat_e3", {31'd0, bus.Din_Ready}, 32'd1);
    @(posedge Clk); #1;
    bus.Din_Valid = 1'b0;
    chk("hs_xdcs", {31'd0, XDCS}, 32'd0);
    chk("hs_mosi_b7", {31'd0, MOSI}, 32'd0);
    chk("hs_busy", {31'd0, Busy}, 32'd1);
    chk("hs_ready", {31'd0, bus.Din_Ready}, 32'd0);
    wait_ready(60);
    pop_chk("byte_3c", 8'h3C);

    // Flush after one byte: HOLD for CLK_DIV cycles, then count cleared
    bus.Flush = 1'b1;
    @(posedge Clk); #1;
    bus.Flush = 1'b0;
    chk("fl_hold_xdcs", {31'd0, XDCS}, 32'd0);
    chk("fl_hold_busy", {31'd0, Busy}, 32'd1);
    @(posedge Clk); #1; chk("fl_xdcs_c1", {31'd0, XDCS}, 32'd0);
    @(posedge Clk); #1; chk("fl_xdcs_c2", {31'd0, XDCS}, 32'd1);
    chk("fl_busy_c2", {31'd0, Busy}, 32'd0);
    @(posedge Clk); #1;
    chk("fl_ready_again", {31'd0, bus.Din_Ready}, 32'd1);
    chk("fl_count_clr_xdcs", {31'd0, XDCS}, 32'd1);

    // Single byte 0xA5 timing
    bus.Din = 8'hA5;
    bus.Din_Valid = 1'b1;
    @(posedge Clk); #1;
    bus.Din_Valid = 1'b0;
    chk("a5_mosi_b7", {31'd0, MOSI}, 32'd1);
    r0 = rise_cnt;
    cyc = 0;
    while (bus.Din_Ready !== 1'b1 && cyc < 60) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) chk("a5_sclk_c1", {31'd0, SCLK}, 32'd0);
      if (cyc == 2) chk("a5_sclk_c2", {31'd0, SCLK}, 32'd1);
    end
    chk("a5_byte_cycles", cyc, 32'd32);
    chk("a5_sclk_idle", {31'd0, SCLK}, 32'd0);
    chk("a5_pulses", rise_cnt - r0, 32'd8);
    chk("a5_xdcs_held", {31'd0, XDCS}, 32'd0);
    pop_chk("byte_a5", 8'hA5);

    // Flush coincident with handshake: byte wins, burst continues
    bus.Din = 8'h5A;
    bus.Din_Valid = 1'b1;
    bus.Flush = 1'b1;
    @(posedge Clk); #1;
    bus.Din_Valid = 1'b0;
    bus.Flush = 1'b0;
    chk("flhs_shift_ready", {31'd0, bus.Din_Ready}, 32'd0);
    chk("flhs_busy", {31'd0, Busy}, 32'd1);
    wait_ready(60);
    pop_chk("byte_5a", 8'h5A);
    chk("flhs_xdcs_held", {31'd0, XDCS}, 32'd0);
    flush_burst();

    // Full burst of 32 with Dreq dropped after byte 10
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i));
      if (i == 9) Dreq = 1'b0;
    end
    cyc = 0;
    while (XDCS !== 1'b1 && cyc < 80) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("burst_end_xdcs_cycles", cyc, 32'd34);
    chk("burst_end_busy", {31'd0, Busy}, 32'd0);
    r0 = rise_cnt;
    bus.Din = 8'h20;
    bus.Din_Valid = 1'b1;
    repeat (40) @(posedge Clk); #1;
    chk("burst_wait_ready", {31'd0, bus.Din_Ready}, 32'd0);
    chk("burst_wait_sclk", rise_cnt - r0, 32'd0);
    chk("burst_wait_xdcs", {31'd0, XDCS}, 32'd1);
    Dreq = 1'b1;
    for (int i = 32; i < 40; i++) send_byte(8'(i));
    wait_ready(60);
    for (int i = 0; i < 40; i++) pop_chk($sformatf("burst_byte_%0d", i), 8'(i));

    // Reset during bit 3 of 0xFF
    bus.Din = 8'hFF;
    bus.Din_Valid = 1'b1;
    @(posedge Clk); #1;
    bus.Din_Valid = 1'b0;
    repeat (14) @(posedge Clk); #1;
    chk("mid_sclk_high", {31'd0, SCLK}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_sclk", {31'd0, SCLK}, 32'd0);
    chk("arst_mosi", {31'd0, MOSI}, 32'd0);
    chk("arst_xdcs", {31'd0, XDCS}, 32'd1);
    chk("arst_ready", {31'd0, bus.Din_Ready}, 32'd0);
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_no_partial", rxq.size(), 32'd0);
    repeat (2) @(posedge Clk); #1;
    Reset = 1'b0;
    send_byte(8'h81);
    wait_ready(60);
    pop_chk("byte_81", 8'h81);
    chk("xdcs_low_at_rises", xdcs_bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
